calc_core_seq: RTL and testbench

- Parametrised sequential calculator core; successor to the fixed 3-bit combinational calculator datapath.
- Operand and opcode entry is driven by button pulses through a state machine: enter A, enter B, select op, show result.
- Multiply is iterative (shift-add); all other ops complete in one cycle.
- Sits between the debounced button front-end and the existing 7-segment display driver. That driver consumes a_val, b_val, op_val, result and state.

---
 rtl/calc_core_seq_if.sv | 28 ++
 rtl/calc_core_seq.sv | 164 ++++++++++++++++
 tb/tb_calc_core_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_core_seq_if.sv
// Button inputs and display-facing outputs of the sequential calculator core.
interface calc_core_seq_if #(
  parameter int WIDTH = 4
);
  logic             enter;
  logic             back;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic [2:0]       op_val;
  logic [1:0]       state;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             res_valid;

  modport master (
    output enter, back, up, down,
    input  a_val, b_val, op_val, state, result, carry, zero, busy, res_valid
  );

  modport slave (
    input  enter, back, up, down,
    output a_val, b_val, op_val, state, result, carry, zero, busy, res_valid
  );
endinterface

// File: rtl/calc_core_seq.sv
// Sequential calculator core: button-driven operand/opcode entry, one-cycle ALU ops and a
// shift-add multiplier. Define ACCUM_EN to chain the result back into operand A.
module calc_core_seq #(
  parameter int WIDTH      = 4,
  parameter int MUL_CYCLES = WIDTH
) (
  input logic            clk,
  input logic            rst,
  calc_core_seq_if.slave bus
);
  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RES = 2'd3
  } state_t;

  localparam int CW = $clog2(MUL_CYCLES + 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic [2:0]         op_q;
  logic               carry_q, zero_q, busy_q, valid_q;
  logic [2*WIDTH-1:0] mul_cand, mul_acc, mul_next;
  logic [WIDTH-1:0]   mul_plier;
  logic [CW-1:0]      mul_cnt;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               inc, dec, mul_last;

  assign inc      = bus.up & ~bus.down;
  assign dec      = bus.down & ~bus.up;
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign mul_next = mul_acc + (mul_plier[0] ? mul_cand : '0);
  assign mul_last = (mul_cnt == CW'(MUL_CYCLES - 1));

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      3'd0: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      3'd1: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      3'd2: alu_res = a_q & b_q;
      3'd3: alu_res = a_q | b_q;
      3'd4: alu_res = a_q ^ b_q;
      3'd5: alu_res = (32'(b_q) >= WIDTH) ? '0 : (a_q << b_q);
      3'd6: alu_res = (32'(b_q) >= WIDTH) ? '0 : (a_q >> b_q);
      default: alu_res = '0;
    endcase
  end

  // Priority inside each state is back > enter > up/down; up with down cancels out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      mul_cand  <= '0;
      mul_acc   <= '0;
      mul_plier <= '0;
      mul_cnt   <= '0;
    end else begin
      case (state_q)
        S_A: begin
          if (bus.back)       a_q     <= '0;
          else if (bus.enter) state_q <= S_B;
          else if (inc)       a_q     <= a_q + WIDTH'(1);
          else if (dec)       a_q     <= a_q - WIDTH'(1);
        end
        S_B: begin
          if (bus.back)       state_q <= S_A;
          else if (bus.enter) state_q <= S_OP;
          else if (inc)       b_q     <= b_q + WIDTH'(1);
          else if (dec)       b_q     <= b_q - WIDTH'(1);
        end
        S_OP: begin
          if (bus.back) begin
            state_q <= S_B;
          end else if (bus.enter) begin
            state_q <= S_RES;
            if (op_q == 3'd7) begin
              busy_q    <= 1'b1;
              valid_q   <= 1'b0;
              mul_cand  <= {{WIDTH{1'b0}}, a_q};
              mul_plier <= b_q;
              mul_acc   <= '0;
              mul_cnt   <= '0;
            end else begin
              res_q   <= alu_res;
              carry_q <= alu_carry;
              zero_q  <= (alu_res == '0);
              valid_q <= 1'b1;
            end
          end else if (inc) begin
            op_q <= op_q + 3'd1;
          end else if (dec) begin
            op_q <= op_q - 3'd1;
          end
        end
        S_RES: begin
          if (busy_q) begin
            if (bus.back) begin
              busy_q  <= 1'b0;
              state_q <= S_OP;
            end else begin
              mul_acc   <= mul_next;
              mul_cand  <= mul_cand << 1;
              mul_plier <= mul_plier >> 1;
              mul_cnt   <= mul_cnt + CW'(1);
              if (mul_last) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
                res_q   <= mul_next[WIDTH-1:0];
                carry_q <= |mul_next[2*WIDTH-1:WIDTH];
                zero_q  <= (mul_next[WIDTH-1:0] == '0);
              end
            end
          end else if (valid_q) begin
            if (bus.back) begin
              valid_q <= 1'b0;
              state_q <= S_OP;
            end else if (bus.enter) begin
              valid_q <= 1'b0;
`ifdef ACCUM_EN
              a_q     <= res_q;
              b_q     <= '0;
              state_q <= S_B;
`else
              a_q     <= '0;
              b_q     <= '0;
              op_q    <= '0;
              state_q <= S_A;
`endif
            end
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign bus.a_val     = a_q;
  assign bus.b_val     = b_q;
  assign bus.op_val    = op_q;
  assign bus.state     = state_q;
  assign bus.result    = res_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
endmodule

// File: tb/tb_calc_core_seq.sv
// Self-checking bench for calc_core_seq at WIDTH=4: vector table with a result scoreboard,
// plus hand-written sequences for wrap-around, multiply abort, reset and result exit.
module tb_calc_core_seq;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic       carry;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    logic       carry;
    logic       zero;
  } exp_t;

  vec_t vecs[15];
  exp_t sb_q[$];

  calc_core_seq_if #(.WIDTH(WIDTH)) bus ();

  calc_core_seq #(.WIDTH(WIDTH), .MUL_CYCLES(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One button pulse lasting exactly one rising edge; returns on the following falling edge.
  task automatic applyStimulus(input logic e, input logic bk, input logic u, input logic d);
    @(negedge clk);
    bus.enter = e;
    bus.back  = bk;
    bus.up    = u;
    bus.down  = d;
    @(negedge clk);
    bus.enter = 1'b0;
    bus.back  = 1'b0;
    bus.up    = 1'b0;
    bus.down  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_operands(input int a, input int b, input int op);
    repeat (a) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (b) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (op) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic wait_result(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) begin
      checkOutput({name, " timeout"}, 0, 1);
    end else if (sb_q.size() == 0) begin
      checkOutput({name, " scoreboard empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({name, " result"}, int'(bus.result), int'(e.res));
      checkOutput({name, " carry"}, int'(bus.carry), int'(e.carry));
      checkOutput({name, " zero"}, int'(bus.zero), int'(e.zero));
    end
  endtask

  task automatic count_busy(input string name, input int expected);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput({name, " busy cycles"}, n, expected);
  endtask

  initial begin
    bus.enter = 1'b0;
    bus.back  = 1'b0;
    bus.up    = 1'b0;
    bus.down  = 1'b0;

    vecs[0]  = '{4'd3,  4'd6,  3'd0, 4'd9,  1'b0, 1'b0};
    vecs[1]  = '{4'd4,  4'd5,  3'd1, 4'd15, 1'b1, 1'b0};
    vecs[2]  = '{4'd2,  4'd4,  3'd5, 4'd0,  1'b0, 1'b1};
    vecs[3]  = '{4'd8,  4'd1,  3'd6, 4'd4,  1'b0, 1'b0};
    vecs[4]  = '{4'd12, 4'd10, 3'd2, 4'd8,  1'b0, 1'b0};
    vecs[5]  = '{4'd12, 4'd10, 3'd3, 4'd14, 1'b0, 1'b0};
    vecs[6]  = '{4'd12, 4'd10, 3'd4, 4'd6,  1'b0, 1'b0};
    vecs[7]  = '{4'd9,  4'd9,  3'd0, 4'd2,  1'b1, 1'b0};
    vecs[8]  = '{4'd5,  4'd5,  3'd1, 4'd0,  1'b0, 1'b1};
    vecs[9]  = '{4'd7,  4'd3,  3'd7, 4'd5,  1'b1, 1'b0};
    vecs[10] = '{4'd3,  4'd5,  3'd7, 4'd15, 1'b0, 1'b0};
    vecs[11] = '{4'd3,  4'd2,  3'd5, 4'd12, 1'b0, 1'b0};
    vecs[12] = '{4'd15, 4'd3,  3'd6, 4'd1,  1'b0, 1'b0};
    vecs[13] = '{4'd0,  4'd0,  3'd7, 4'd0,  1'b0, 1'b1};
    vecs[14] = '{4'd15, 4'd15, 3'd0, 4'd14, 1'b1, 1'b0};

    do_reset();
    checkOutput("reset a_val", int'(bus.a_val), 0);
    checkOutput("reset b_val", int'(bus.b_val), 0);
    checkOutput("reset op_val", int'(bus.op_val), 0);
    checkOutput("reset state", int'(bus.state), 0);
    checkOutput("reset result", int'(bus.result), 0);
    checkOutput("reset flags", int'({bus.carry, bus.zero, bus.busy, bus.res_valid}), 0);

    for (int i = 0; i < 15; i++) begin
      do_reset();
      load_operands(int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].op));
      checkOutput($sformatf("vec%0d a_val", i), int'(bus.a_val), int'(vecs[i].a));
      checkOutput($sformatf("vec%0d b_val", i), int'(bus.b_val), int'(vecs[i].b));
      checkOutput($sformatf("vec%0d op_val", i), int'(bus.op_val), int'(vecs[i].op));
      sb_q.push_back('{vecs[i].res, vecs[i].carry, vecs[i].zero});
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d state", i), int'(bus.state), 3);
      if (vecs[i].op == 3'd7) begin
        checkOutput($sformatf("vec%0d valid at start", i), int'(bus.res_valid), 0);
        count_busy($sformatf("vec%0d", i), WIDTH);
      end else begin
        checkOutput($sformatf("vec%0d latency", i), int'(bus.res_valid), 1);
      end
      wait_result($sformatf("vec%0d", i));
    end

    // Operand wrap-around and simultaneous up/down.
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("down wrap a_val", int'(bus.a_val), 15);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("up+down a_val", int'(bus.a_val), 15);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("up wrap a_val", int'(bus.a_val), 0);

    // Back from S_B keeps A; back in S_A clears it.
    do_reset();
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("S_B back state", int'(bus.state), 0);
    checkOutput("S_B back a_val", int'(bus.a_val), 5);
    checkOutput("S_B back b_val", int'(bus.b_val), 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("S_A back clears a_val", int'(bus.a_val), 0);
    checkOutput("S_A back beats enter", int'(bus.state), 0);

    // Multiply aborted by back on the second busy cycle.
    do_reset();
    load_operands(7, 3, 7);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("abort busy start", int'(bus.busy), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("abort busy", int'(bus.busy), 0);
    checkOutput("abort state", int'(bus.state), 2);
    checkOutput("abort res_valid", int'(bus.res_valid), 0);

    // Restart multiply; enter and up pulses while busy must be ignored.
    sb_q.push_back('{4'd5, 1'b1, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    wait_result("mul ignore");
    checkOutput("mul ignore state", int'(bus.state), 3);
    checkOutput("mul ignore a_val", int'(bus.a_val), 7);
    checkOutput("mul ignore op_val", int'(bus.op_val), 7);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("res back state", int'(bus.state), 2);
    checkOutput("res back res_valid", int'(bus.res_valid), 0);
    checkOutput("res back b_val", int'(bus.b_val), 3);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre-reset busy", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    checkOutput("mid reset busy", int'(bus.busy), 0);
    checkOutput("mid reset state", int'(bus.state), 0);
    checkOutput("mid reset a_val", int'(bus.a_val), 0);
    checkOutput("mid reset b_val", int'(bus.b_val), 0);
    checkOutput("mid reset op_val", int'(bus.op_val), 0);
    checkOutput("mid reset result", int'(bus.result), 0);
    checkOutput("mid reset flags", int'({bus.carry, bus.zero, bus.res_valid}), 0);
    @(negedge clk);
    rst = 1'b1;

    // Leaving S_RES with enter.
    do_reset();
    load_operands(3, 6, 0);
    sb_q.push_back('{4'd9, 1'b0, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    wait_result("exit add");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("exit res_valid", int'(bus.res_valid), 0);
`ifdef ACCUM_EN
    checkOutput("accum a_val", int'(bus.a_val), 9);
    checkOutput("accum b_val", int'(bus.b_val), 0);
    checkOutput("accum op_val", int'(bus.op_val), 0);
    checkOutput("accum state", int'(bus.state), 1);
`else
    checkOutput("exit a_val", int'(bus.a_val), 0);
    checkOutput("exit b_val", int'(bus.b_val), 0);
    checkOutput("exit op_val", int'(bus.op_val), 0);
    checkOutput("exit state", int'(bus.state), 0);
`endif

    checkOutput("scoreboard drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
